// File: rtl/reg_wr_arbiter.sv
// ----------------------------------------------------------------------------
// reg_wr_arbiter
//   Shares the register file's single write port between NUM_REQ writeback
//   sources (0 = ALU, 1 = load return, 2 = debug poke) with round-robin
//   arbitration and a valid/ready handshake per source. A single registered
//   output stage drives the write port. Its contents are also exported as a
//   bypass view for operand forwarding in decode.
//
// Ports
//   clk, rst           clock; asynchronous active-low reset
//   req_valid/ready    per-source handshake; ready is one-hot or zero
//   req_addr/data      per-source destination register and data, packed [i]
//   reg_w_en/addr/data register file write port (registered)
//   byp_valid/addr/data  mirror of the output stage for forwarding
//   last_grant         index of the most recently accepted source
// ----------------------------------------------------------------------------
module reg_wr_arbiter #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_REQ    = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          reg_w_en,
  output logic [ADDR_WIDTH-1:0]         reg_w_addr,
  output logic [DATA_WIDTH-1:0]         reg_w_data,
  output logic                          byp_valid,
  output logic [ADDR_WIDTH-1:0]         byp_addr,
  output logic [DATA_WIDTH-1:0]         byp_data,
  output logic [$clog2(NUM_REQ)-1:0]    last_grant
);

  localparam int unsigned GNT_W = $clog2(NUM_REQ);

  // Round-robin pointer; doubles as the exported last_grant.
  logic [GNT_W-1:0]      rr_ptr;

  // Output stage.
  logic                  stage_valid;
  logic [ADDR_WIDTH-1:0] stage_addr;
  logic [DATA_WIDTH-1:0] stage_data;

  // Arbitration results.
  logic [NUM_REQ-1:0]    grant_vec;
  logic                  grant_any;
  logic [GNT_W-1:0]      grant_idx;
  logic [GNT_W-1:0]      cand;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  // Search from rr_ptr+1 upward with wrap; first valid source wins.
  // Nothing is granted while reset is asserted.
  always_comb begin
    grant_vec = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = GNT_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!grant_any && rst && req_valid[cand]) begin
        grant_any       = 1'b1;
        grant_idx       = cand;
        grant_vec[cand] = 1'b1;
      end
    end
  end

  // Select the granted source's payload.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_vec[i]) begin
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Ready is independent of stage occupancy: the stage drains every cycle.
  assign req_ready = grant_vec;

  // Output stage and pointer. Without a grant the stage empties but keeps
  // its last address/data so the bypass view stays quiet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_valid <= 1'b0;
      stage_addr  <= '0;
      stage_data  <= '0;
      rr_ptr      <= '0;
    end else if (grant_any) begin
      stage_valid <= 1'b1;
      stage_addr  <= sel_addr;
      stage_data  <= sel_data;
      rr_ptr      <= grant_idx;
    end else begin
      stage_valid <= 1'b0;
    end
  end

  assign reg_w_en   = stage_valid;
  assign reg_w_addr = stage_addr;
  assign reg_w_data = stage_data;
  assign byp_valid  = stage_valid;
  assign byp_addr   = stage_addr;
  assign byp_data   = stage_data;
  assign last_grant = rr_ptr;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Scoreboard bench for reg_wr_arbiter: stimulus side predicts grants with a
// round-robin reference model and queues expected writes; a monitor pops and
// compares whenever the write port is (or should be) active.
module tb_reg_wr_arbiter;

  localparam int N  = 3;
  localparam int AW = 4;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr  = '0;
  logic [N*DW-1:0] req_data  = '0;
  logic [N-1:0]    req_ready;
  logic            reg_w_en, byp_valid;
  logic [AW-1:0]   reg_w_addr, byp_addr;
  logic [DW-1:0]   reg_w_data, byp_data;
  logic [1:0]      last_grant;

  reg_wr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .reg_w_en(reg_w_en), .reg_w_addr(reg_w_addr), .reg_w_data(reg_w_data),
    .byp_valid(byp_valid), .byp_addr(byp_addr), .byp_data(byp_data),
    .last_grant(last_grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          src;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            last_m = 0;   // model: most recent accepted source
  int            last_win = -1;
  logic [DW-1:0] rf [16];      // register file sink

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (reg_w_en) rf[reg_w_addr] <= reg_w_data;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: round-robin from last_m+1; check ready and queue write.
  task automatic eval_cycle();
    int win;
    logic [N-1:0] e;
    win = -1;
    e = '0;
    for (int k = 1; k <= N; k++) begin
      int s;
      s = (last_m + k) % N;
      if (win < 0 && req_valid[s]) win = s;
    end
    if (win >= 0) e[win] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(e));
    if (win >= 0) begin
      q.push_back('{cyc + 1, win, req_addr[win*AW +: AW], req_data[win*DW +: DW]});
      last_m = win;
    end
    last_win = win;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
    @(posedge clk); #1;
    req_valid = v;
    req_addr  = a;
    req_data  = d;
    @(negedge clk);
    eval_cycle();
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Monitor: compares the write port against the scoreboard every cycle.
  initial begin
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        while (q.size() > 0 && q[0].due < cyc) begin
          check("missed_write", 32'(q[0].due), 32'(cyc));
          void'(q.pop_front());
        end
        if (q.size() > 0 && q[0].due == cyc) begin
          exp_t e;
          e = q.pop_front();
          check("w_en",       32'(reg_w_en),   32'(1));
          check("w_addr",     32'(reg_w_addr), 32'(e.addr));
          check("w_data",     32'(reg_w_data), 32'(e.data));
          check("byp_valid",  32'(byp_valid),  32'(1));
          check("byp_addr",   32'(byp_addr),   32'(e.addr));
          check("byp_data",   32'(byp_data),   32'(e.data));
          check("last_grant", 32'(last_grant), 32'(e.src));
        end else begin
          check("idle_w_en",  32'(reg_w_en),   32'(0));
          check("idle_byp",   32'(byp_valid),  32'(0));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int order [6];
    int exp_order [6];
    int wait1, max_wait;
    logic [N-1:0] regen;
    logic [N-1:0] v;
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] d;

    for (int i = 0; i < 16; i++) rf[i] = '0;
    exp_order[0] = 1; exp_order[1] = 2; exp_order[2] = 0;
    exp_order[3] = 1; exp_order[4] = 2; exp_order[5] = 0;

    // Reset with every source requesting.
    rst = 1'b0;
    req_valid = '1;
    repeat (3) @(negedge clk);
    check("rst_ready",      32'(req_ready),  32'(0));
    check("rst_w_en",       32'(reg_w_en),   32'(0));
    check("rst_last_grant", 32'(last_grant), 32'(0));
    check("rst_w_addr",     32'(reg_w_addr), 32'(0));
    req_valid = '0;
    rst = 1'b1;
    last_m = 0;

    // All sources valid for 6 cycles: order 1,2,0,1,2,0.
    for (int i = 0; i < 6; i++) begin
      drive('1, {4'd10, 4'd9, 4'd8}, {16'h3000 + 16'(i), 16'h2000 + 16'(i), 16'h1000 + 16'(i)});
      order[i] = onehot_idx(req_ready);
    end
    for (int i = 0; i < 6; i++) check($sformatf("rr_order_%0d", i), 32'(order[i]), 32'(exp_order[i]));

    // Single source 0: addr 5, data BEEF.
    drive(3'b001, {4'd0, 4'd0, 4'd5}, {16'h0, 16'h0, 16'hBEEF});
    check("single_ready", 32'(req_ready), 32'(3'b001));
    drive(3'b000, '0, '0);
    check("single_n1_en",   32'(reg_w_en),   32'(1));
    check("single_n1_addr", 32'(reg_w_addr), 32'(5));
    check("single_n1_data", 32'(reg_w_data), 32'(16'hBEEF));
    drive(3'b000, '0, '0);
    check("single_n2_en",   32'(reg_w_en),   32'(0));

    // Sources 0 and 2 write addr 3; source 2 commits first, 0 persists.
    check("pre_same_last", 32'(last_grant), 32'(0));
    drive(3'b101, {4'd3, 4'd0, 4'd3}, {16'h2222, 16'h0, 16'h1111});
    check("same_first", 32'(req_ready), 32'(3'b100));
    drive(3'b001, {4'd3, 4'd0, 4'd3}, {16'h2222, 16'h0, 16'h1111});
    check("same_second", 32'(req_ready), 32'(3'b001));
    drive(3'b000, '0, '0);
    drive(3'b000, '0, '0);
    check("same_addr_final", 32'(rf[3]), 32'(16'h1111));

    // Reset while the stage holds {7, AAAA}: write is dropped.
    drive(3'b001, {4'd0, 4'd0, 4'd7}, {16'h0, 16'h0, 16'hAAAA});
    @(posedge clk); #1;
    req_valid = '1;
    #2;
    rst = 1'b0;
    #1;
    check("async_w_en",   32'(reg_w_en),   32'(0));
    check("async_byp",    32'(byp_valid),  32'(0));
    check("async_addr",   32'(reg_w_addr), 32'(0));
    check("async_last",   32'(last_grant), 32'(0));
    check("async_ready",  32'(req_ready),  32'(0));
    q.delete();
    last_m = 0;
    repeat (2) @(negedge clk);
    check("reset_reg7", 32'(rf[7]), 32'(0));
    req_valid = '0;
    rst = 1'b1;

    // First grant after reset is source 1.
    drive(3'b111, {4'd2, 4'd1, 4'd0}, {16'h0C, 16'h0B, 16'h0A});
    check("post_rst_first", 32'(req_ready), 32'(3'b010));
    drive(3'b000, '0, '0);

    // Source 1 held valid; sources 0 and 2 toggle randomly.
    regen = '1;
    wait1 = 0;
    max_wait = 0;
    v = '0; a = '0; d = '0;
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < N; i++) begin
        if (regen[i]) begin
          a[i*AW +: AW] = AW'($urandom);
          d[i*DW +: DW] = DW'($urandom);
        end
      end
      v[0] = 1'($urandom);
      v[1] = 1'b1;
      v[2] = 1'($urandom);
      drive(v, a, d);
      for (int i = 0; i < N; i++) regen[i] = (last_win == i) || !v[i];
      if (!req_ready[1]) wait1++;
      else wait1 = 0;
      if (wait1 > max_wait) max_wait = wait1;
    end
    check("src1_max_wait_le2", 32'(max_wait <= 2), 32'(1));

    drive(3'b000, '0, '0);
    drive(3'b000, '0, '0);
    check("scoreboard_empty", 32'(q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
